// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to a
// PS/2 device. Both PS/2 lines are open-drain: an *_oe output of 1 means the
// pad is pulled low, 0 means it is released.
//
// Sequence: inhibit the clock, issue the request-to-send (clock + data low),
// release the clock, then present one bit per device falling clock edge.
// The device ACKs by holding data low at edge 11.
//
// Ports:
//   clk          system clock (100 MHz)
//   rst          asynchronous, active-high reset
//   tx_data      command byte, latched when tx_valid & tx_ready
//   tx_valid     request to send tx_data
//   tx_ready     high in IDLE
//   tx_done      one-cycle pulse: ACK received and both lines back to idle
//   tx_err       one-cycle pulse: NACK or timeout
//   busy         high in every state except IDLE
//   ps2_clk_in   raw PS2Clk pad level
//   ps2_data_in  raw PS2Data pad level
//   ps2_clk_oe   1 = pull PS2Clk low
//   ps2_data_oe  1 = pull PS2Data low
//
// Optional build macro PS2_TX_RETRY_EN: on NACK or timeout the same byte is
// resent from INHIBIT, up to two retries; tx_err pulses only after the third
// failure and busy stays high throughout. Without the macro the first failure
// goes straight to ERR.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | lines released, waiting for tx_valid
// INHIBIT   | clock held low for INHIBIT_CYCLES
// REQ       | clock and data held low (start bit) for REQ_CYCLES
// SHIFT     | clock released; one frame bit per device falling edge
// WAIT_IDLE | ACK seen; waiting for both lines to return high
// ERR       | NACK or timeout; pulse tx_err for one cycle

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int REQ_CYCLES     = 200,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CW  = 14;
  localparam int TW  = 21;
  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_WAIT_IDLE,
    ST_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic             filt_clk_q, filt_clk_d;
  logic             filt_data_q, filt_data_d;
  logic [FCW-1:0]   fcnt_clk_q, fcnt_clk_d;
  logic [FCW-1:0]   fcnt_data_q, fcnt_data_d;
  logic             fall_clk_q, fall_clk_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [3:0]       n_q, n_d;
  logic [9:0]       frame_q, frame_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             tx_done_q, tx_done_d;
  logic             fail;
  logic             tmo_hit;
`ifdef PS2_TX_RETRY_EN
  logic [7:0]       byte_q, byte_d;
  logic [1:0]       retry_q, retry_d;
`endif

  // --------------------------------------------------------------------
  // Input conditioning: 2-FF synchronizer, then a level filter that only
  // follows the synchronized input after FILTER_LEN consecutive samples
  // that disagree with the current filtered level.
  // --------------------------------------------------------------------
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};

    filt_clk_d = filt_clk_q;
    fcnt_clk_d = '0;
    if (clk_sync_q[1] != filt_clk_q) begin
      if (fcnt_clk_q == FCW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_sync_q[1];
      end else begin
        fcnt_clk_d = fcnt_clk_q + 1'b1;
      end
    end

    filt_data_d = filt_data_q;
    fcnt_data_d = '0;
    if (data_sync_q[1] != filt_data_q) begin
      if (fcnt_data_q == FCW'(FILTER_LEN - 1)) begin
        filt_data_d = data_sync_q[1];
      end else begin
        fcnt_data_d = fcnt_data_q + 1'b1;
      end
    end

    fall_clk_d = filt_clk_q & ~filt_clk_d;
  end

  // --------------------------------------------------------------------
  // Transmit FSM
  // --------------------------------------------------------------------
  // Timeout counter only runs once the clock has been released.
  assign tmo_hit = (tmo_q >= TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    n_d       = n_q;
    frame_d   = frame_q;
    data_oe_d = data_oe_q;
    tx_done_d = 1'b0;
    fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    byte_d    = byte_q;
    retry_d   = retry_q;
`endif

    if ((state_q == ST_SHIFT || state_q == ST_WAIT_IDLE) && (tmo_q != '1)) begin
      tmo_d = tmo_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          frame_d = {1'b1, ~^tx_data, tx_data};
          cnt_d   = CW'(INHIBIT_CYCLES - 1);
          tmo_d   = '0;
          n_d     = '0;
          state_d = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          byte_d  = tx_data;
          retry_d = '0;
`endif
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == '0) begin
          cnt_d     = CW'(REQ_CYCLES - 1);
          data_oe_d = 1'b1;
          state_d   = ST_REQ;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_REQ: begin
        if (cnt_q == '0) begin
          n_d     = 4'd1;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_SHIFT: begin
        // Timeout wins over a coincident clock edge.
        if (tmo_hit) begin
          fail = 1'b1;
        end else if (fall_clk_q) begin
          if (n_q == 4'd11) begin
            if (!filt_data_q) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              fail = 1'b1;
            end
          end else begin
            data_oe_d = ~frame_q[0];
            frame_d   = {1'b0, frame_q[9:1]};
            n_d       = n_q + 1'b1;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (tmo_hit) begin
          fail = 1'b1;
        end else if (filt_clk_q && filt_data_q) begin
          tx_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_ERR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fail) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d = retry_q + 1'b1;
        frame_d = {1'b1, ~^byte_q, byte_q};
        cnt_d   = CW'(INHIBIT_CYCLES - 1);
        tmo_d   = '0;
        n_d     = '0;
        state_d = ST_INHIBIT;
      end else begin
        state_d = ST_ERR;
      end
`else
      state_d = ST_ERR;
`endif
    end

    // Pad enables are registered from the next state so they change
    // together with the state and never glitch.
    clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_REQ);
    if (state_d == ST_REQ) begin
      data_oe_d = 1'b1;
    end else if (state_d != ST_SHIFT) begin
      data_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_clk_q  <= 1'b1;
      filt_data_q <= 1'b1;
      fcnt_clk_q  <= '0;
      fcnt_data_q <= '0;
      fall_clk_q  <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      n_q         <= '0;
      frame_q     <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      tx_done_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      byte_q      <= '0;
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_clk_q  <= filt_clk_d;
      filt_data_q <= filt_data_d;
      fcnt_clk_q  <= fcnt_clk_d;
      fcnt_data_q <= fcnt_data_d;
      fall_clk_q  <= fall_clk_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      n_q         <= n_d;
      frame_q     <= frame_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      tx_done_q   <= tx_done_d;
`ifdef PS2_TX_RETRY_EN
      byte_q      <= byte_d;
      retry_q     <= retry_d;
`endif
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign tx_done     = tx_done_q;
  assign tx_err      = (state_q == ST_ERR);

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the sending counterpart of the keyboard receiver.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives PS2Clk/PS2Data as open-drain through output-enable pins; the top level ties the pad low when oe=1 and releases it otherwise.
- Runs on the 100 MHz system clock; `busy` lets the receiver ignore frames while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 12000: cycles the clock is held low before the request (120 us at 100 MHz).
- REQ_CYCLES, 200: cycles with clock and data both held low before the clock is released.
- TIMEOUT_CYCLES, 2000000: maximum cycles from clock release to the ACK edge (20 ms).
- FILTER_LEN, 8: consecutive equal synchronized samples needed to accept a line level change.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- tx_data  in  8  command byte
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  high in IDLE; transfer accepted when tx_valid & tx_ready
- tx_done  out  1  one-cycle pulse: device ACKed and the lines returned to idle
- tx_err  out  1  one-cycle pulse: NACK or timeout
- busy  out  1  high in every state except IDLE
- ps2_clk_in  in  1  raw PS2Clk pad level
- ps2_data_in  in  1  raw PS2Data pad level
- ps2_clk_oe  out  1  1 = pull PS2Clk low
- ps2_data_oe  out  1  1 = pull PS2Data low

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; clk_oe=0, data_oe=0; tx_done=0, tx_err=0; busy=0; tx_ready=1.
  - Filtered levels are preset to 1.
  - Reset mid-frame releases both lines immediately; no pulse is issued.
- Input conditioning:
  - Each raw input passes a 2-FF synchronizer, then a filter.
  - The filtered level changes only after FILTER_LEN consecutive equal samples.
  - fall_clk = filtered PS2Clk transition 1->0, one cycle wide.
- Frame shift register, loaded on accept: {stop=1, parity=~^tx_data, tx_data[7:0]}, sent LSB first.
  - The start bit is driven in REQ.
  - Data bits go out on edges 1-8, parity on edge 9, stop (data released) on edge 10.
- Acceptance:
  - tx_data is latched on the cycle tx_valid & tx_ready.
  - tx_valid is ignored while busy.
- FSM:
  - IDLE: clk_oe=0, data_oe=0. On accept -> INHIBIT; clk_oe=1 on the next cycle.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES, then -> REQ.
  - REQ: clk_oe=1, data_oe=1 (start bit) for REQ_CYCLES, then -> SHIFT. Entering SHIFT releases clk_oe; data_oe stays 1.
  - SHIFT:
    - Edge counter n=0..11.
    - On fall_clk n=1..10: data_oe = ~frame[n-1], then n++.
    - On fall_clk n=11: sample filtered data. 0 -> WAIT_IDLE (ACK). 1 -> ERR (NACK).
  - WAIT_IDLE: both oe=0. When filtered clk=1 and data=1, pulse tx_done, -> IDLE.
  - ERR: both oe=0. Pulse tx_err for one cycle, -> IDLE.
- Timeout:
  - A cycle counter starts at clock release and is cleared on each accept.
  - Reaching TIMEOUT_CYCLES in SHIFT or WAIT_IDLE -> ERR.
- Simultaneous events: timeout and fall_clk in the same cycle resolves to timeout.
- Counters:
  - Inhibit/request counter: 14 bits.
  - Timeout counter: 21 bits, saturating.
  - No counter wraps.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- Defined:
  - On NACK or timeout, re-latch the same byte and restart from INHIBIT, up to 2 retries.
  - tx_err pulses only after the third failure.
  - busy stays high through retries.
- Undefined: the first failure goes to ERR. Retry logic is absent.

Test Plan:
- Send 0xED with the device model ACKing:
  - clk_oe low for 12000 cycles, then data_oe low for 200 cycles.
  - Device samples 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once after the lines idle; tx_err stays 0.
- Send 0xF4, then 0x01 -> parity bits sampled 0 and 0; both complete with tx_done.
- Device leaves data high at edge 11 -> tx_err pulses once, no tx_done, both oe=0, tx_ready=1 next cycle.
- Device never clocks -> tx_err exactly TIMEOUT_CYCLES after clock release.
- 3-cycle low glitch on ps2_clk_in during SHIFT -> not counted; the frame still decodes 0xED correctly.
- Assert rst at edge 5 of a frame -> both oe=0 immediately, IDLE, no pulses. A new tx_valid after reset sends a full frame. A tx_valid pulse while busy is ignored.
